// File: rtl/bash_pkg.sv
// Shared types, rotation constants and word helpers for the Bash S-layer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bash_pkg;

    typedef logic [63:0] word_t;
    typedef word_t [23:0] state_t;

    typedef struct packed {
        logic [5:0] m1;
        logic [5:0] n1;
        logic [5:0] m2;
        logic [5:0] n2;
    } rot_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Per-column rotation constants (m1, n1, m2, n2), column 0 first.
    localparam rot_t BASH_S_ROT [8] = '{
        '{6'd8,  6'd53, 6'd14, 6'd1 },
        '{6'd56, 6'd51, 6'd34, 6'd7 },
        '{6'd8,  6'd37, 6'd46, 6'd49},
        '{6'd56, 6'd3,  6'd2,  6'd23},
        '{6'd8,  6'd21, 6'd14, 6'd33},
        '{6'd56, 6'd19, 6'd34, 6'd39},
        '{6'd8,  6'd5,  6'd46, 6'd17},
        '{6'd56, 6'd35, 6'd2,  6'd55}
    };

    // Words are stored in octet-little-endian memory order; reversing the
    // octets gives the arithmetic value the rotations are defined on.
    function automatic word_t octet_rev(input word_t w);
        word_t r;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = w[8*(7-b) +: 8];
        end
        return r;
    endfunction

    // Rotate-left on the arithmetic value of a memory-order word.
    function automatic word_t rot_hi(input word_t w, input logic [5:0] r);
        logic [127:0] tmp;
        tmp = {octet_rev(w), octet_rev(w)} << r;
        return octet_rev(tmp[127:64]);
    endfunction

endpackage

// File: rtl/bash_s_layer_if.sv
// Handshake and data bus of the Bash S-layer (input state in, output state out).
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; the slave modport is the S-layer.
interface bash_s_layer_if;
    import bash_pkg::*;

    logic   s_valid_i;
    logic   s_ready_o;
    state_t s_data_i;
    logic   m_valid_o;
    logic   m_ready_i;
    state_t m_data_o;
    logic   busy_o;

    modport slave (
        input  s_valid_i, s_data_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o, busy_o
    );

    modport master (
        output s_valid_i, s_data_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o, busy_o
    );
endinterface

// File: rtl/bash_s.sv
// Bash S-box on one column (w0, w1, w2) with runtime rotation constants.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module bash_s
    import bash_pkg::*;
(
    input  word_t      i_w0,
    input  word_t      i_w1,
    input  word_t      i_w2,
    input  logic [5:0] i_m1,
    input  logic [5:0] i_n1,
    input  logic [5:0] i_m2,
    input  logic [5:0] i_n2,
    output word_t      o_w0,
    output word_t      o_w1,
    output word_t      o_w2
);
    word_t w_s0;
    word_t w_t1;
    word_t w_s1;
    word_t w_s2;

    assign w_s0 = i_w0 ^ i_w1 ^ i_w2;
    assign w_t1 = i_w1 ^ rot_hi(w_s0, i_n1);
    assign w_s1 = rot_hi(i_w0, i_m1) ^ w_t1;
    assign w_s2 = i_w2 ^ rot_hi(i_w2, i_m2) ^ rot_hi(w_t1, i_n2);

    assign o_w0 = w_s0 ^ (~w_s2 | w_s1);
    assign o_w1 = w_s1 ^ (w_s0 | w_s2);
    assign o_w2 = w_s2 ^ (w_s0 & w_s1);
endmodule

// File: rtl/bash_s_layer.sv
// Applies the Bash S-box to all 8 columns of a 24-word state, LANES columns per cycle.
// Latency: 8/LANES + PIPE + 1 cycles from accept to m_valid_o.
// Backpressure: one state in flight; s_ready_o only in IDLE, DONE held until m_ready_i.
module bash_s_layer
    import bash_pkg::*;
#(
    parameter int LANES = 2,
    parameter int PIPE  = 0
) (
    input logic          clk_i,
    input logic          rst_i,
    bash_s_layer_if.slave bus
);
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("bash_s_layer: LANES must be 1, 2, 4 or 8");
    end
    if (!(PIPE == 0 || PIPE == 1)) begin : g_bad_pipe
        $error("bash_s_layer: PIPE must be 0 or 1");
    end

    state_e     r_state;
    state_e     w_next;
    logic [2:0] r_col;
    state_t     r_buf;

    logic w_accept;
    logic w_run;
    logic w_last;
    logic w_s_ready;
    logic w_m_valid;
    logic w_busy;

    // Lane outputs and the write-back view (direct or one cycle delayed).
    word_t      w_l0  [LANES];
    word_t      w_l1  [LANES];
    word_t      w_l2  [LANES];
    logic [2:0] w_lc  [LANES];
    logic       w_wb_en;
    word_t      w_wb0 [LANES];
    word_t      w_wb1 [LANES];
    word_t      w_wb2 [LANES];
    logic [2:0] w_wbc [LANES];

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = (r_state == ST_IDLE) && bus.s_valid_i;
    assign w_last   = (r_col == 3'(8 - LANES));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; FLUSH only exists to retire the last pipelined group.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.s_valid_i) w_next = ST_RUN;
            ST_RUN:   if (w_last) w_next = (PIPE != 0) ? ST_FLUSH : ST_DONE;
            ST_FLUSH: w_next = ST_DONE;
            ST_DONE:  if (bus.m_ready_i) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state alone.
    always_comb begin
        w_s_ready = 1'b0;
        w_m_valid = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            ST_IDLE:         w_s_ready = 1'b1;
            ST_RUN, ST_FLUSH: w_busy   = 1'b1;
            ST_DONE:         w_m_valid = 1'b1;
            default:         ;
        endcase
    end

    assign bus.s_ready_o = w_s_ready;
    assign bus.m_valid_o = w_m_valid;
    assign bus.busy_o    = w_busy;
    assign bus.m_data_o  = r_buf;

    // Column counter: restarts on accept, steps one group per RUN cycle and wraps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         r_col <= 3'd0;
        else if (w_accept) r_col <= 3'd0;
        else if (w_run)    r_col <= r_col + 3'(LANES);
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [2:0] w_c;
        logic [4:0] w_k;
        rot_t       w_rot;

        assign w_c   = r_col + 3'(i);
        assign w_k   = {2'b00, w_c};
        assign w_rot = BASH_S_ROT[w_c];
        assign w_lc[i] = w_c;

        bash_s u_sbox (
            .i_w0 (r_buf[w_k]),
            .i_w1 (r_buf[w_k + 5'd8]),
            .i_w2 (r_buf[w_k + 5'd16]),
            .i_m1 (w_rot.m1),
            .i_n1 (w_rot.n1),
            .i_m2 (w_rot.m2),
            .i_n2 (w_rot.n2),
            .o_w0 (w_l0[i]),
            .o_w1 (w_l1[i]),
            .o_w2 (w_l2[i])
        );
    end

    if (PIPE != 0) begin : g_pipe
        logic       r_pv;
        word_t      r_p0 [LANES];
        word_t      r_p1 [LANES];
        word_t      r_p2 [LANES];
        logic [2:0] r_pc [LANES];

        // Hold each issued group for one cycle; it is written back the next cycle.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_pv <= 1'b0;
                for (int i = 0; i < LANES; i++) begin
                    r_p0[i] <= '0;
                    r_p1[i] <= '0;
                    r_p2[i] <= '0;
                    r_pc[i] <= '0;
                end
            end else begin
                r_pv <= w_run;
                for (int i = 0; i < LANES; i++) begin
                    r_p0[i] <= w_l0[i];
                    r_p1[i] <= w_l1[i];
                    r_p2[i] <= w_l2[i];
                    r_pc[i] <= w_lc[i];
                end
            end
        end

        assign w_wb_en = r_pv;
        assign w_wb0   = r_p0;
        assign w_wb1   = r_p1;
        assign w_wb2   = r_p2;
        assign w_wbc   = r_pc;
    end else begin : g_nopipe
        assign w_wb_en = w_run;
        assign w_wb0   = w_l0;
        assign w_wb1   = w_l1;
        assign w_wb2   = w_l2;
        assign w_wbc   = w_lc;
    end

    // State buffer: loaded on accept, columns overwritten in place as groups retire.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_buf <= '0;
        end else if (w_accept) begin
            r_buf <= bus.s_data_i;
        end else if (w_wb_en) begin
            for (int i = 0; i < LANES; i++) begin
                r_buf[5'(w_wbc[i])]         <= w_wb0[i];
                r_buf[5'(w_wbc[i]) + 5'd8]  <= w_wb1[i];
                r_buf[5'(w_wbc[i]) + 5'd16] <= w_wb2[i];
            end
        end
    end
endmodule

// File: tb/tb_bash_s_layer.sv
// Bench for bash_s_layer: all eight LANES/PIPE variants run side by side on shared stimulus.
// Latency: each variant is checked cycle by cycle against its own expected timing.
// Backpressure: random and held m_ready_i, plus a mid-run reset.
module tb_bash_s_layer;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b1;
    logic [1535:0] s_data = '0;

    logic [7:0]    rdy;
    logic [7:0]    vld;
    logic [7:0]    bsy;
    logic [1535:0] md [8];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_dut
        localparam int L = 1 << (g / 2);
        localparam int P = g % 2;

        bash_s_layer_if u_if ();

        assign u_if.s_valid_i = s_valid;
        assign u_if.s_data_i  = s_data;
        assign u_if.m_ready_i = m_ready;
        assign rdy[g] = u_if.s_ready_o;
        assign vld[g] = u_if.m_valid_o;
        assign bsy[g] = u_if.busy_o;
        assign md[g]  = u_if.m_data_o;

        bash_s_layer #(.LANES(L), .PIPE(P)) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (u_if.slave)
        );
    end

    // ---------------- reference model ----------------
    localparam int M1 [8] = '{8, 56, 8, 56, 8, 56, 8, 56};
    localparam int N1 [8] = '{53, 51, 37, 3, 21, 19, 5, 35};
    localparam int M2 [8] = '{14, 34, 46, 2, 14, 34, 46, 2};
    localparam int N2 [8] = '{1, 7, 49, 23, 33, 39, 17, 55};

    function automatic logic [63:0] rothi(input logic [63:0] w, input int r);
        logic [63:0] v;
        v = {<<8{w}};
        v = (v << r) | (v >> (64 - r));
        return {<<8{v}};
    endfunction

    function automatic logic [1535:0] s_layer(input logic [1535:0] s);
        logic [1535:0] o;
        logic [63:0] w0, w1, w2, a, t, b, c;
        o = s;
        for (int j = 0; j < 8; j++) begin
            w0 = s[64*j +: 64];
            w1 = s[64*(8+j) +: 64];
            w2 = s[64*(16+j) +: 64];
            a = w0 ^ w1 ^ w2;
            t = w1 ^ rothi(a, N1[j]);
            b = rothi(w0, M1[j]) ^ t;
            c = w2 ^ rothi(w2, M2[j]) ^ rothi(t, N2[j]);
            o[64*j +: 64]      = a ^ (~c | b);
            o[64*(8+j) +: 64]  = b ^ (a | c);
            o[64*(16+j) +: 64] = c ^ (a & b);
        end
        return o;
    endfunction

    function automatic logic [1535:0] rnd_state();
        logic [1535:0] r;
        for (int i = 0; i < 48; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic int lat_of(input int g);
        return 8 / (1 << (g / 2)) + (g % 2) + 1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [1535:0] act, input logic [1535:0] exp);
        int w;
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            w = 0;
            for (int k = 23; k >= 0; k--) if (act[64*k +: 64] !== exp[64*k +: 64]) w = k;
            $display("FAIL %s: word %0d actual %h required %h", nm, w, act[64*w +: 64], exp[64*w +: 64]);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    bit            pend     [8];
    int            kc       [8];
    bit            seen     [8];
    int            lat_seen [8];
    logic [1535:0] exp_d    [8];
    logic [1535:0] last_out [8];
    bit            ev;

    // Each cycle: expected ready/valid/busy/data follow from cycles since accept.
    always @(negedge clk) begin
        if (rst) begin
            for (int g = 0; g < 8; g++) begin
                pend[g] = 1'b0;
                seen[g] = 1'b0;
            end
        end else begin
            for (int g = 0; g < 8; g++) begin
                if (pend[g]) kc[g]++;
                ev = pend[g] && (kc[g] >= lat_of(g));
                chk($sformatf("s_ready[%0d]", g), 64'(rdy[g]), 64'(!pend[g]));
                chk($sformatf("m_valid[%0d]", g), 64'(vld[g]), 64'(ev));
                chk($sformatf("busy[%0d]", g), 64'(bsy[g]), 64'(pend[g] && !ev));
                if (vld[g] && pend[g] && !seen[g]) begin
                    seen[g] = 1'b1;
                    lat_seen[g] = kc[g];
                end
                if (ev) chkd($sformatf("m_data[%0d]", g), md[g], exp_d[g]);
                if (!pend[g] && s_valid) begin
                    pend[g]  = 1'b1;
                    kc[g]    = 0;
                    seen[g]  = 1'b0;
                    exp_d[g] = s_layer(s_data);
                end else if (ev && m_ready) begin
                    pend[g]     = 1'b0;
                    last_out[g] = md[g];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start(input logic [1535:0] d);
        int n = 0;
        while (rdy != 8'hFF && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("start_wait_ready", 64'(rdy), 64'hFF);
        s_data  = d;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        do begin
            m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            n++;
        end while (rdy != 8'hFF && n < 200);
        chk("drain_wait_ready", 64'(rdy), 64'hFF);
        m_ready = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"}, 64'(rdy), 64'hFF);
        chk({tag, "_m_valid"}, 64'(vld), 64'h00);
        chk({tag, "_busy"},    64'(bsy), 64'h00);
        for (int g = 0; g < 8; g++) chkd($sformatf("%s_m_data[%0d]", tag, g), md[g], '0);
    endtask

    logic [1535:0] zero_exp;
    logic [1535:0] ones_exp;
    logic [1535:0] ones_in;

    initial begin
        zero_exp = '0;
        ones_exp = '0;
        ones_in  = '1;
        for (int k = 0; k < 8; k++)  zero_exp[64*k +: 64] = '1;
        for (int k = 16; k < 24; k++) ones_exp[64*k +: 64] = '1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        // Pin the model to hand-derived results.
        chkd("model_zero", s_layer('0), zero_exp);
        chkd("model_ones", s_layer(ones_in), ones_exp);

        // All-zero state.
        start('0);
        drain(1'b0);
        for (int g = 0; g < 8; g++) chkd($sformatf("zero_out[%0d]", g), last_out[g], zero_exp);
        chk("latency_L2_P0", 64'(lat_seen[2]), 64'd5);
        chk("latency_L1_P1", 64'(lat_seen[1]), 64'd10);

        // All-ones state.
        start(ones_in);
        drain(1'b0);
        for (int g = 0; g < 8; g++) chkd($sformatf("ones_out[%0d]", g), last_out[g], ones_exp);
        chk("latency_L8_P1", 64'(lat_seen[7]), 64'd3);

        // Random states with random downstream stalls.
        for (int it = 0; it < 24; it++) begin
            start(rnd_state());
            drain(1'b1);
        end

        // Held backpressure with a second state offered meanwhile.
        m_ready = 1'b0;
        start(rnd_state());
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 12) begin
                s_data  = rnd_state();
                s_valid = 1'b1;
            end
        end
        chk("bp_s_ready_low", 64'(rdy), 64'h00);
        chk("bp_m_valid_high", 64'(vld), 64'hFF);
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", 64'(rdy), 64'hFF);

        // Reset in the second RUN cycle.
        start(rnd_state());
        @(posedge clk); #1;
        chk("pre_reset_busy_L1", 64'(bsy[1:0]), 64'h3);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        @(posedge clk); #1;
        chk_reset_vals("rst_edge");
        rst = 1'b0;
        start('0);
        drain(1'b0);
        for (int g = 0; g < 8; g++) chkd($sformatf("post_rst_zero[%0d]", g), last_out[g], zero_exp);

        // Back-to-back states.
        start(rnd_state());
        drain(1'b0);
        start(rnd_state());
        drain(1'b0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
